spi_block_rx: RTL
=================

Name: spi_block_rx

Overview:
- Receive-side framing stage directly upstream of the CRC-32 checker.
- Oversamples a mode-0 SPI bit stream (spi_clk, cs_n, mosi) in the system clock domain.
- Presents each bit to the CRC checker with correct setup, and assembles payload bytes into a small FIFO drained via valid/ready.
- After PAYLOAD_BYTES payload bytes plus CRC_BYTES trailer bytes, samples the checker's pass flag and reports packet status.

Parameters:
- PAYLOAD_BYTES, 512, payload bytes per packet (>=1).
- CRC_BYTES, 4, trailer bytes fed to the CRC only, never pushed to the FIFO.
- FIFO_DEPTH, 4, payload byte FIFO entries (power of two, >=2).

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- spi_clk_i  in  1  asynchronous SPI clock
- spi_cs_n_i  in  1  asynchronous chip select, active low
- spi_mosi_i  in  1  asynchronous serial data, MSB first
- data_o  out  8  FIFO head byte
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  consumer accepts data_o when valid_o & ready_i
- crc_bit_o  out  1  bit to the CRC checker's data_i
- crc_en_o  out  1  one-cycle shift strobe to the CRC checker's en_i (its clk_en_i is tied high)
- crc_rst_o  out  1  one-cycle CRC clear pulse
- crc_ok_i  in  1  CRC checker pass flag (residue match)
- pkt_done_o  out  1  one-cycle pulse, packet complete
- pkt_ok_o  out  1  CRC result; valid while pkt_done_o=1, holds until next packet start
- pkt_abort_o  out  1  one-cycle pulse, cs_n rose mid-packet
- overflow_o  out  1  sticky; a payload byte was dropped because the FIFO was full

Behaviour:
- Reset (reset_i=1 at a clk_i edge): all outputs 0, FIFO empty, state IDLE, counters 0, synchronizers cleared to cs_n=1, clk=0, mosi=0.
- Input sync: two-flop synchronizer on each SPI input.
- Rising edge = synchronized clk is 1 and was 0 last cycle; synchronized mosi is sampled in that same cycle.
- A cs_n falling edge (synchronized) in any state:
  - crc_rst_o=1 for one cycle.
  - Clears bit/byte counters, overflow_o and pkt_ok_o.
  - Enters PAYLOAD.
  - The FIFO is not flushed.
- CRC timing (cycle S = sampling cycle):
  - crc_bit_o loads the sampled bit at S+1 and holds until the next sample.
  - crc_en_o pulses at S+2, because the checker registers data_i one cycle before use.
  - Every sampled bit in PAYLOAD and CRC is fed this way.
- Byte assembly:
  - 3-bit bit counter, MSB-first shift register.
  - On the 8th bit in PAYLOAD, the byte is pushed at S+1.
  - If the FIFO is full and no pop occurs in that cycle, the byte is dropped and overflow_o=1.
  - A push and a pop in the same cycle while full both succeed.
  - The byte counter advances regardless of a drop.
- States:
  - IDLE: edges ignored.
  - PAYLOAD: after byte PAYLOAD_BYTES-1 completes -> CRC.
  - CRC: after CRC_BYTES bytes -> CHECK.
  - CHECK: waits for the final crc_en_o pulse (cycle E), samples crc_ok_i at E+1, then pkt_done_o=1 and pkt_ok_o=crc_ok_i at E+2 -> IDLE.
- Abort: a synchronized cs_n rising edge in PAYLOAD, CRC or CHECK gives pkt_abort_o=1 for one cycle, pkt_ok_o=0, -> IDLE. A partial byte is discarded and no pkt_done_o is produced. cs_n rising in IDLE has no effect.
- Extra SPI edges in IDLE after completion are ignored until the next cs_n falling edge.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits; wrap naturally.
- Byte counter: width $clog2(PAYLOAD_BYTES+CRC_BYTES).
- Reset mid-packet: immediate return to the reset state. No done or abort pulse is generated.

Decomposition:
- Shared package: state enum (IDLE, PAYLOAD, CRC, CHECK) and constant CRC32_BYTES=4.
- One sub-module: sync_fifo (width 8, depth FIFO_DEPTH; push, pop, full, empty, head).
- The two-flop synchronizers stay inline.

Test Plan:
- PAYLOAD_BYTES=2, frame A5,3C + 4 trailer bytes, real CRC checker, correct CRC-32/POSIX trailer from a bench model, ready_i=1 -> data_o A5 then 3C, 48 crc_en_o pulses, pkt_done_o with pkt_ok_o=1.
- Same frame with one trailer bit flipped -> pkt_done_o with pkt_ok_o=0; FIFO still delivers A5,3C.
- Bit setup check over the first byte: crc_bit_o changes exactly one cycle before each crc_en_o pulse; crc_rst_o pulses once at the cs_n fall.
- FIFO_DEPTH=2, PAYLOAD_BYTES=4, ready_i=0 -> first two bytes retained, overflow_o=1 after the 3rd byte; then ready_i=1 -> exactly 2 bytes drained, valid_o=0.
- cs_n raised after 13 bits -> pkt_abort_o pulse, no pkt_done_o, one byte in FIFO; next frame completes normally and overflow_o is cleared.
- reset_i asserted mid-CRC phase -> all outputs 0 the next cycle; a new frame afterwards passes.

Source files
------------

// File: rtl/spi_block_rx_pkg.sv
// Shared types for the SPI receive framing stage that feeds the CRC-32 checker.
package spi_block_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2,
    ST_CHECK   = 2'd3
  } rx_state_e;

  localparam int CRC32_BYTES = 4;

endpackage

// File: rtl/spi_block_rx_sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push_s, do_pop_s;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign head_o    = mem_q[rptr_q[AW-1:0]];

  // Next-state pointers and storage
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push_s) begin
      mem_d[wptr_q[AW-1:0]] = push_data_i;
      wptr_d = wptr_q + (AW+1)'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Pointer and storage registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/spi_block_rx.sv
// Oversampled mode-0 SPI receiver: feeds every frame bit to the CRC checker and
// queues payload bytes, then reports the checker's verdict once the trailer is in.
module spi_block_rx
  import spi_block_rx_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 512,
  parameter int CRC_BYTES     = CRC32_BYTES,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       spi_clk_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_mosi_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       crc_bit_o,
  output logic       crc_en_o,
  output logic       crc_rst_o,
  input  logic       crc_ok_i,
  output logic       pkt_done_o,
  output logic       pkt_ok_o,
  output logic       pkt_abort_o,
  output logic       overflow_o
);
  localparam int TOTAL_BYTES = PAYLOAD_BYTES + CRC_BYTES;
  localparam int CNT_W       = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_CRC = CNT_W'(TOTAL_BYTES - 1);

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic [7:0]       push_data_q, push_data_d;
  logic             push_q, push_d;
  logic             crc_bit_q, crc_bit_d;
  logic             en_pipe_q, en_pipe_d;
  logic             crc_en_q, crc_en_d;
  logic             crc_rst_q, crc_rst_d;
  logic             chk_wait_q, chk_wait_d;
  logic             pkt_done_q, pkt_done_d;
  logic             pkt_ok_q, pkt_ok_d;
  logic             pkt_abort_q, pkt_abort_d;
  logic             overflow_q, overflow_d;

  logic       cs_fall_s, cs_rise_s, clk_rise_s;
  logic       fifo_full_s, fifo_empty_s;
  logic [7:0] byte_s;

  assign cs_fall_s  = ~cs_sync_q & cs_prev_q;
  assign cs_rise_s  = cs_sync_q & ~cs_prev_q;
  assign clk_rise_s = clk_sync_q & ~clk_prev_q;
  assign byte_s     = {shift_q, mosi_sync_q};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push_q),
    .push_data_i (push_data_q),
    .pop_i       (ready_i),
    .head_o      (data_o),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  // Framing state machine, bit/byte assembly and the CRC feed pipeline
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    push_data_d = push_data_q;
    crc_bit_d   = crc_bit_q;
    pkt_ok_d    = pkt_ok_q;
    overflow_d  = overflow_q;
    push_d      = 1'b0;
    en_pipe_d   = 1'b0;
    crc_rst_d   = 1'b0;
    chk_wait_d  = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_abort_d = 1'b0;
    // The checker latches data_i a cycle before it shifts, hence the extra stage.
    crc_en_d    = en_pipe_q;
    if (push_q && fifo_full_s && !ready_i) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    if (cs_fall_s) begin
      crc_rst_d  = 1'b1;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = '0;
      overflow_d = 1'b0;
      pkt_ok_d   = 1'b0;
      state_d    = ST_PAYLOAD;
    end else if (cs_rise_s && (state_q != ST_IDLE)) begin
      pkt_abort_d = 1'b1;
      pkt_ok_d    = 1'b0;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_PAYLOAD, ST_CRC: begin
          if (clk_rise_s) begin
            crc_bit_d = mosi_sync_q;
            en_pipe_d = 1'b1;
            shift_d   = byte_s[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_cnt_d = byte_cnt_q + CNT_W'(1);
              if (state_q == ST_PAYLOAD) begin
                push_d      = 1'b1;
                push_data_d = byte_s;
                if (byte_cnt_q == LAST_PAY) state_d = ST_CRC;
                else                        state_d = ST_PAYLOAD;
              end else if (byte_cnt_q == LAST_CRC) begin
                state_d = ST_CHECK;
              end else begin
                state_d = ST_CRC;
              end
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_CHECK: begin
          if (chk_wait_q) begin
            pkt_done_d = 1'b1;
            pkt_ok_d   = crc_ok_i;
            state_d    = ST_IDLE;
          end else if (crc_en_q) begin
            chk_wait_d = 1'b1;
          end else begin
            chk_wait_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Synchronizers and all state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      clk_meta_q  <= 1'b0;
      clk_sync_q  <= 1'b0;
      clk_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= '0;
      shift_q     <= 7'd0;
      push_data_q <= 8'd0;
      push_q      <= 1'b0;
      crc_bit_q   <= 1'b0;
      en_pipe_q   <= 1'b0;
      crc_en_q    <= 1'b0;
      crc_rst_q   <= 1'b0;
      chk_wait_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_abort_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      cs_meta_q   <= spi_cs_n_i;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      clk_meta_q  <= spi_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      mosi_meta_q <= spi_mosi_i;
      mosi_sync_q <= mosi_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      push_data_q <= push_data_d;
      push_q      <= push_d;
      crc_bit_q   <= crc_bit_d;
      en_pipe_q   <= en_pipe_d;
      crc_en_q    <= crc_en_d;
      crc_rst_q   <= crc_rst_d;
      chk_wait_q  <= chk_wait_d;
      pkt_done_q  <= pkt_done_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_abort_q <= pkt_abort_d;
      overflow_q  <= overflow_d;
    end
  end

  assign valid_o     = ~fifo_empty_s;
  assign crc_bit_o   = crc_bit_q;
  assign crc_en_o    = crc_en_q;
  assign crc_rst_o   = crc_rst_q;
  assign pkt_done_o  = pkt_done_q;
  assign pkt_ok_o    = pkt_ok_q;
  assign pkt_abort_o = pkt_abort_q;
  assign overflow_o  = overflow_q;

endmodule
